hbm_req_arbiter: RTL and testbench

- Shares one hbm_controller user port (addr/data_in/wr_en/rd_en, data_out/hbm_ready/hbm_error) between NUM_REQ requesters.
- Round-robin grant with one outstanding HBM command at a time.
- Returns read data and error status to the granted requester.
- Sits directly upstream of hbm_controller; requesters are DMA/compute ports.

---
 rtl/hbm_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_hbm_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_req_arbiter.sv
// Round-robin arbiter sharing one hbm_controller user port between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining HBM_ARB_TIMEOUT_EN.
module hbm_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err,
  output logic [ADDR_W-1:0]           hbm_addr,
  output logic [DATA_W-1:0]           hbm_wdata,
  output logic                        hbm_wr_en,
  output logic                        hbm_rd_en,
  input  logic [DATA_W-1:0]           hbm_rdata,
  input  logic                        hbm_ready,
  input  logic                        hbm_error,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);
  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_d;

  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     win;
  logic              found;
  logic              accept;
  logic              we_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timed_out;
  int unsigned       idx;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[GW'(idx)]) begin
        found     = 1'b1;
        win       = GW'(idx);
        sel_we    = req_we[GW'(idx)];
        sel_addr  = req_addr[idx*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = (state == IDLE) && hbm_ready && found;
  assign busy   = (state != IDLE);

`ifdef HBM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already spent; saturates at TIMEOUT_CYC.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (state == ISSUE)
      wait_cnt <= '0;
    else if (state == WAIT && wait_cnt != TW'(TIMEOUT_CYC))
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && (wait_cnt >= TW'(TIMEOUT_CYC - 1));
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    req_ready  = '0;
    resp_valid = '0;
    hbm_wr_en  = 1'b0;
    hbm_rd_en  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[win] = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        hbm_wr_en = we_q;
        hbm_rd_en = !we_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (hbm_error || hbm_ready || timed_out)
          state_d = RESP;
      end
      RESP: begin
        resp_valid[grant_id] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      we_q       <= 1'b0;
      hbm_addr   <= '0;
      hbm_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        grant_id  <= win;
        we_q      <= sel_we;
        hbm_addr  <= sel_addr;
        hbm_wdata <= sel_wdata;
      end
      // Error outranks ready; a write completion leaves resp_rdata untouched.
      if (state == WAIT) begin
        if (hbm_error) begin
          resp_err <= 1'b1;
        end else if (hbm_ready) begin
          resp_err <= 1'b0;
          if (!we_q)
            resp_rdata <= hbm_rdata;
        end else if (timed_out) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
      end
      if (state == RESP)
        rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_hbm_req_arbiter.sv
// Directed bench for hbm_req_arbiter: vector table of arbitration transactions plus
// hand-written sequences for slow read, error, backpressure, reset and timeout.
module tb_hbm_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 512;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  resp_valid;
  logic [DW-1:0]  resp_rdata;
  logic           resp_err;
  logic [AW-1:0]  hbm_addr;
  logic [DW-1:0]  hbm_wdata;
  logic           hbm_wr_en;
  logic           hbm_rd_en;
  logic [DW-1:0]  hbm_rdata = '0;
  logic           hbm_ready = 1'b0;
  logic           hbm_error = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] tb_addr [NR];
  logic [DW-1:0] tb_wdata [NR];

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] we;
    int            win;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs [7];

  hbm_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .hbm_addr(hbm_addr), .hbm_wdata(hbm_wdata), .hbm_wr_en(hbm_wr_en), .hbm_rd_en(hbm_rd_en),
    .hbm_rdata(hbm_rdata), .hbm_ready(hbm_ready), .hbm_error(hbm_error),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = tb_addr[i];
      req_wdata[i*DW +: DW] = tb_wdata[i];
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_we    = '0;
    hbm_ready = 1'b0;
    hbm_error = 1'b0;
    hbm_rdata = '0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Entered in IDLE just after an edge; controller answers on the first WAIT cycle.
  task automatic run_txn(input logic [NR-1:0] valid, input logic [NR-1:0] we,
                         input logic [DW-1:0] rdata, input int win,
                         input logic [DW-1:0] exp_rdata, input bit hold);
    logic [NR-1:0] oh;
    logic          exp_we;
    oh        = 4'b0001 << win;
    exp_we    = we[win];
    req_valid = valid;
    req_we    = we;
    hbm_ready = 1'b1;
    hbm_error = 1'b0;
    hbm_rdata = rdata;
    #1;
    chk("idle_req_ready", req_ready, oh);
    chk("idle_busy", busy, 1'b0);
    chk("idle_resp_valid", resp_valid, '0);
    step();
    if (!hold) req_valid = '0;
    chk("issue_grant_id", grant_id, win);
    chk("issue_wr_en", hbm_wr_en, exp_we);
    chk("issue_rd_en", hbm_rd_en, !exp_we);
    chk("issue_addr", hbm_addr, tb_addr[win]);
    chk("issue_wdata", hbm_wdata, tb_wdata[win]);
    chk("issue_req_ready", req_ready, '0);
    chk("issue_busy", busy, 1'b1);
    step();
    chk("wait_strobes", {hbm_wr_en, hbm_rd_en}, 2'b00);
    step();
    chk("resp_valid", resp_valid, oh);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", resp_err, 1'b0);
    chk("resp_no_ready", req_ready, '0);
    chk("resp_addr_hold", hbm_addr, tb_addr[win]);
    step();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      tb_addr[i]  = 32'h100 + 32'(i) * 32'h10;
      tb_wdata[i] = DW'(32'hA0 + 32'(i));
    end
    pack();
    vecs[0] = '{valid: 4'b0001, we: 4'b0001, win: 0, rdata: DW'(32'h5000), exp_rdata: '0};
    vecs[1] = '{valid: 4'b1111, we: 4'b0000, win: 1, rdata: DW'(32'h5001), exp_rdata: DW'(32'h5001)};
    vecs[2] = '{valid: 4'b1011, we: 4'b0000, win: 3, rdata: DW'(32'h5002), exp_rdata: DW'(32'h5002)};
    vecs[3] = '{valid: 4'b0110, we: 4'b0000, win: 1, rdata: DW'(32'h5003), exp_rdata: DW'(32'h5003)};
    vecs[4] = '{valid: 4'b0011, we: 4'b0000, win: 0, rdata: DW'(32'h5004), exp_rdata: DW'(32'h5004)};
    vecs[5] = '{valid: 4'b1000, we: 4'b1000, win: 3, rdata: DW'(32'h5005), exp_rdata: DW'(32'h5004)};
    vecs[6] = '{valid: 4'b0100, we: 4'b0100, win: 2, rdata: DW'(32'h5006), exp_rdata: DW'(32'h5004)};

    // Reset values
    do_reset();
    chk("rst_req_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_hbm_addr", hbm_addr, '0);
    chk("rst_hbm_wdata", hbm_wdata, '0);
    chk("rst_strobes", {hbm_wr_en, hbm_rd_en}, 2'b00);

    // Round-robin vector table, pointer starts at 0
    for (int v = 0; v < 7; v++)
      run_txn(vecs[v].valid, vecs[v].we, vecs[v].rdata, vecs[v].win, vecs[v].exp_rdata, 1'b0);

    // Single write to addr 0x10
    do_reset();
    tb_addr[0]  = 32'h10;
    tb_wdata[0] = DW'(32'hDEADBEEF);
    pack();
    run_txn(4'b0001, 4'b0001, '0, 0, '0, 1'b0);

    // Fairness with all requesters held valid
    do_reset();
    for (int g = 0; g < 8; g++)
      run_txn(4'b1111, 4'b0000, DW'(32'h6000 + g), g % 4, DW'(32'h6000 + g), 1'b1);
    req_valid = '0;

    // Slow read from requester 2
    tb_addr[2] = 32'h40;
    pack();
    req_valid = 4'b0100;
    req_we    = '0;
    hbm_ready = 1'b1;
    #1;
    chk("slow_req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    hbm_ready = 1'b0;
    chk("slow_rd_en", hbm_rd_en, 1'b1);
    chk("slow_addr", hbm_addr, 32'h40);
    for (int w = 0; w < 3; w++) begin
      step();
      chk("slow_wait_resp", resp_valid, '0);
      chk("slow_wait_busy", busy, 1'b1);
    end
    hbm_ready = 1'b1;
    hbm_rdata = DW'(32'h1234_5678);
    step();
    chk("slow_resp_valid", resp_valid, 4'b0100);
    chk("slow_resp_rdata", resp_rdata, DW'(32'h1234_5678));
    chk("slow_resp_err", resp_err, 1'b0);
    step();

    // Error on requester 1 (error outranks ready), next grant to requester 2
    do_reset();
    run_txn(4'b0001, 4'b0000, DW'(32'h7000), 0, DW'(32'h7000), 1'b0);
    req_valid = 4'b1111;
    req_we    = '0;
    hbm_ready = 1'b1;
    #1;
    chk("err_req_ready", req_ready, 4'b0010);
    step();
    step();
    hbm_error = 1'b1;
    step();
    hbm_error = 1'b0;
    chk("err_resp_valid", resp_valid, 4'b0010);
    chk("err_resp_err", resp_err, 1'b1);
    step();
    chk("err_next_grant", req_ready, 4'b0100);

    // Backpressure in IDLE, then reset during WAIT
    do_reset();
    run_txn(4'b0001, 4'b0000, DW'(32'h8000), 0, DW'(32'h8000), 1'b0);
    req_valid = 4'b1111;
    hbm_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_no_ready", req_ready, '0);
      chk("bp_busy", busy, 1'b0);
      step();
    end
    hbm_ready = 1'b1;
    #1;
    chk("bp_grant1", req_ready, 4'b0010);
    step();
    hbm_ready = 1'b0;
    step();
    step();
    chk("bp_wait_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_resp_valid", resp_valid, '0);
    chk("rstmid_grant_id", grant_id, '0);
    step();
    chk("rstmid_no_resp", resp_valid, '0);
    hbm_ready = 1'b1;
    #1;
    chk("rstmid_grant0", req_ready, 4'b0001);
    step();
    req_valid = '0;

`ifdef HBM_ARB_TIMEOUT_EN
    // Silent controller: forced error after 64 WAIT cycles
    do_reset();
    run_txn(4'b0001, 4'b0000, DW'(32'hBEEF), 0, DW'(32'hBEEF), 1'b0);
    req_valid = 4'b1000;
    req_we    = '0;
    hbm_ready = 1'b1;
    #1;
    chk("to_req_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    hbm_ready = 1'b0;
    step();
    begin
      int waited;
      waited = 0;
      while (resp_valid == '0 && waited < 200) begin
        step();
        waited++;
      end
      chk("to_wait_cycles", waited, 64);
      chk("to_resp_valid", resp_valid, 4'b1000);
      chk("to_resp_err", resp_err, 1'b1);
      chk("to_resp_rdata", resp_rdata, '0);
    end
`else
    // Silent controller: WAIT persists
    do_reset();
    req_valid = 4'b1000;
    req_we    = '0;
    hbm_ready = 1'b1;
    #1;
    chk("hang_req_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    hbm_ready = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        step();
        if (resp_valid != '0) seen = 1'b1;
      end
      chk("hang_no_resp", seen, 1'b0);
      chk("hang_busy", busy, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
